// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the d16 instruction-fetch front end: FSM states and
// the opcode bit that announces an extension word.
package fetch_unit_pkg;

    localparam logic [1:0] FETCH_S_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_S_FETCH = 2'd1;
    localparam logic [1:0] FETCH_S_WAIT  = 2'd2;

    // Opcode bit 15 set means the following word is the immediate.
    localparam int EXT_BIT = 15;

    typedef enum logic [1:0] {
        S_IDLE  = FETCH_S_IDLE,
        S_FETCH = FETCH_S_FETCH,
        S_WAIT  = FETCH_S_WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular prefetch queue: each entry holds an instruction word and its byte
// address. Supports push, pop of one or two entries, and a flush.
module fetch_unit_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  pop1,
    input  logic                  pop2,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] second_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      pop_cnt;
    logic [PTR_W-1:0]      pop_step;

    always_comb begin
        pop_cnt  = pop2 ? CNT_W'(2) : (pop1 ? CNT_W'(1) : '0);
        pop_step = PTR_W'(pop_cnt);
    end

    // A flush wins over a simultaneous push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr + pop_step;
            count  <= count + CNT_W'(push) - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            data_mem[wr_ptr] <= push_data;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    assign head_data   = data_mem[rd_ptr];
    assign head_pc     = pc_mem[rd_ptr];
    assign second_data = data_mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction prefetcher for the d16 core. Define FETCH_BYPASS_EN to
// forward a single-word response straight to the decoder when the queue is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    input  logic                  mem_wait,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_ext,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] START_PC = {RESET_PC[ADDR_WIDTH-1:1], 1'b0};

    fetch_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  inflight, inflight_epoch, epoch;
    logic                  accept, resp_ok, room, bypass;
    logic [CNT_W-1:0]      count, occupancy;
    logic [DATA_WIDTH-1:0] head_data, second_data;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  head_ext, q_valid, push, pop1, pop2;

    assign occupancy = count + CNT_W'(inflight);
    assign room      = occupancy < CNT_W'(DEPTH);
    assign accept    = mem_req && !mem_wait;
    assign mem_addr  = fetch_pc[ADDR_WIDTH-1:1];
    // Responses from before a redirect carry a stale epoch and are dropped.
    assign resp_ok   = inflight && (inflight_epoch == epoch) && !redirect_valid;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = !mem_stall && room;
                if (mem_req && mem_wait) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mem_req = !mem_stall;
                if (mem_stall || !mem_wait) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (redirect_valid) state_nxt = S_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            fetch_pc       <= START_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            resp_pc        <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= accept;
            if (accept) begin
                inflight_epoch <= epoch;
                resp_pc        <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
                epoch    <= ~epoch;
            end else if (accept) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(2);
            end
        end
    end

    assign head_ext = head_data[EXT_BIT];
    assign q_valid  = (count != '0) && (!head_ext || count >= CNT_W'(2));

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && resp_ok && !mem_rdata[EXT_BIT] && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_ext   = '0;
        instr_pc    = '0;
        next_pc     = fetch_pc;
        if (bypass) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
            instr_pc    = resp_pc;
            next_pc     = resp_pc + ADDR_WIDTH'(2);
        end else if (q_valid) begin
            instr_valid = 1'b1;
            instr       = head_data;
            instr_ext   = head_ext ? second_data : '0;
            instr_pc    = head_pc;
            next_pc     = head_pc + (head_ext ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2));
        end
    end

    assign push = resp_ok && !bypass;
    assign pop1 = instr_ready && q_valid && !head_ext;
    assign pop2 = instr_ready && q_valid && head_ext;

    fetch_unit_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .clear       (redirect_valid),
        .push        (push),
        .push_data   (mem_rdata),
        .push_pc     (resp_pc),
        .pop1        (pop1),
        .pop2        (pop2),
        .count       (count),
        .head_data   (head_data),
        .head_pc     (head_pc),
        .second_data (second_data)
    );

endmodule
